// File: rtl/udma_ptp_ts_pkg.sv
// Shared definitions for the uDMA <-> PTP timestamp bridges (TX and RX).
package udma_ptp_ts_pkg;

  localparam int unsigned TS_WIDTH   = 96;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned HOLD_WIDTH = TS_WIDTH - WORD_WIDTH;

  // uDMA datasize encoding for 32-bit words
  localparam logic [1:0] DATASIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD2 = 2'd1,
    WORD3 = 2'd2
  } ts_state_e;

endpackage

// File: rtl/udma_ptp_ts_tx.sv
// Packs three uDMA TX words into one 96-bit PTP timestamp and emits it on AXI-Stream.
module udma_ptp_ts_tx
  import udma_ptp_ts_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk_ptp,
  input  logic                  rst_ptp,
  input  logic                  clr_i,
  output logic [1:0]            data_tx_datasize_o,
  input  logic [WORD_WIDTH-1:0] data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic [TS_WIDTH-1:0]   ptp_ts_axis_tdata,
  output logic                  ptp_ts_axis_tvalid,
  input  logic                  ptp_ts_axis_tready,
  output logic [CNT_WIDTH-1:0]  ts_count_o,
  output logic                  busy_o
);

  ts_state_e             state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_q;
  logic [TS_WIDTH-1:0]   tdata_q;
  logic                  tvalid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic accept;
  logic load;
  logic drain;

  assign data_tx_datasize_o = DATASIZE_WORD;
  assign ptp_ts_axis_tdata  = tdata_q;
  assign ptp_ts_axis_tvalid = tvalid_q;
  assign ts_count_o         = cnt_q;
  assign drain              = tvalid_q & ptp_ts_axis_tready;

  // State register
  always_ff @(posedge clk_ptp or posedge rst_ptp) begin
    if (rst_ptp) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, word handshake and busy flag
  always_comb begin
    state_d         = state_q;
    data_tx_ready_o = 1'b0;
    busy_o          = (state_q != IDLE);
    accept          = 1'b0;
    load            = 1'b0;

    case (state_q)
      IDLE:    data_tx_ready_o = 1'b1;
      WORD2:   data_tx_ready_o = 1'b1;
      // last word may only enter when the output slot is free or draining now
      WORD3:   data_tx_ready_o = ~tvalid_q | ptp_ts_axis_tready;
      default: data_tx_ready_o = 1'b0;
    endcase

    if (clr_i || rst_ptp) begin
      data_tx_ready_o = 1'b0;
    end

    accept = data_tx_valid_i & data_tx_ready_o;
    load   = accept & (state_q == WORD3);

    if (clr_i) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE:    state_d = WORD2;
        WORD2:   state_d = WORD3;
        WORD3:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Hold register for the first two words
  always_ff @(posedge clk_ptp or posedge rst_ptp) begin
    if (rst_ptp) begin
      hold_q <= '0;
    end else if (clr_i) begin
      hold_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        hold_q[HOLD_WIDTH-1 -: WORD_WIDTH] <= data_tx_i;
      end else if (state_q == WORD2) begin
        hold_q[WORD_WIDTH-1:0] <= data_tx_i;
      end
    end
  end

  // Output slot: a new load takes precedence over a drain in the same cycle
  always_ff @(posedge clk_ptp or posedge rst_ptp) begin
    if (rst_ptp) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (load) begin
        tdata_q  <= {hold_q, data_tx_i};
        tvalid_q <= 1'b1;
      end else if (drain) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  // Delivered-timestamp counter, wraps naturally
  always_ff @(posedge clk_ptp or posedge rst_ptp) begin
    if (rst_ptp) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_udma_ptp_ts_tx.sv
// Directed bench for the 3-word to 96-bit PTP timestamp packer.
module tb_udma_ptp_ts_tx;
  import udma_ptp_ts_pkg::*;

  localparam int unsigned CW = 4;

  logic                  clk_ptp = 1'b0;
  logic                  rst_ptp = 1'b1;
  logic                  clr_i = 1'b0;
  logic [1:0]            data_tx_datasize_o;
  logic [WORD_WIDTH-1:0] data_tx_i = '0;
  logic                  data_tx_valid_i = 1'b0;
  logic                  data_tx_ready_o;
  logic [TS_WIDTH-1:0]   ptp_ts_axis_tdata;
  logic                  ptp_ts_axis_tvalid;
  logic                  ptp_ts_axis_tready = 1'b1;
  logic [CW-1:0]         ts_count_o;
  logic                  busy_o;

  udma_ptp_ts_tx #(.CNT_WIDTH(CW)) dut (
    .clk_ptp            (clk_ptp),
    .rst_ptp            (rst_ptp),
    .clr_i              (clr_i),
    .data_tx_datasize_o (data_tx_datasize_o),
    .data_tx_i          (data_tx_i),
    .data_tx_valid_i    (data_tx_valid_i),
    .data_tx_ready_o    (data_tx_ready_o),
    .ptp_ts_axis_tdata  (ptp_ts_axis_tdata),
    .ptp_ts_axis_tvalid (ptp_ts_axis_tvalid),
    .ptp_ts_axis_tready (ptp_ts_axis_tready),
    .ts_count_o         (ts_count_o),
    .busy_o             (busy_o)
  );

  always #5 clk_ptp = ~clk_ptp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          v;
    logic [31:0]   d;
    logic          tr;
    logic          clr;
    logic          e_rdy;
    logic          e_busy;
    logic          e_tv;
    logic [95:0]   e_td;
    logic [CW-1:0] e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic tr,
                              input logic clr, input logic e_rdy, input logic e_busy,
                              input logic e_tv, input logic [95:0] e_td,
                              input logic [CW-1:0] e_cnt);
    vec_t r;
    r.v = v; r.d = d; r.tr = tr; r.clr = clr;
    r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_tv = e_tv; r.e_td = e_td; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic send_words(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_ptp);
      data_tx_valid_i = 1'b1;
      data_tx_i       = base + 32'(k);
    end
    @(negedge clk_ptp);
    data_tx_valid_i = 1'b0;
  endtask

  logic [95:0] t1, t2, t3, t4, exp_td;
  logic [31:0] w [0:32];
  logic        exp_tv;

  initial begin
    t1 = 96'hAAAA0001_00000002_00000003;
    t2 = 96'h11111111_22222222_33333333;
    t3 = 96'h44444444_55555555_66666666;
    t4 = 96'hC0000001_C0000002_C0000003;

    //              v  data          tr clr rdy busy tv tdata cnt
    vecs[0]  = mk(1, 32'hAAAA0001, 1, 0, 1, 0, 0, 96'h0, 0);
    vecs[1]  = mk(1, 32'h00000002, 1, 0, 1, 1, 0, 96'h0, 0);
    vecs[2]  = mk(1, 32'h00000003, 1, 0, 1, 1, 0, 96'h0, 0);
    vecs[3]  = mk(0, 32'h0,        1, 0, 1, 0, 1, t1,    0);
    vecs[4]  = mk(0, 32'h0,        0, 0, 1, 0, 0, t1,    1);
    vecs[5]  = mk(1, 32'h11111111, 0, 0, 1, 0, 0, t1,    1);
    vecs[6]  = mk(1, 32'h22222222, 0, 0, 1, 1, 0, t1,    1);
    vecs[7]  = mk(1, 32'h33333333, 0, 0, 1, 1, 0, t1,    1);
    vecs[8]  = mk(1, 32'h44444444, 0, 0, 1, 0, 1, t2,    1);
    vecs[9]  = mk(1, 32'h55555555, 0, 0, 1, 1, 1, t2,    1);
    vecs[10] = mk(1, 32'h66666666, 0, 0, 0, 1, 1, t2,    1);
    vecs[11] = mk(1, 32'h66666666, 0, 0, 0, 1, 1, t2,    1);
    vecs[12] = mk(1, 32'h66666666, 1, 0, 1, 1, 1, t2,    1);
    vecs[13] = mk(0, 32'h0,        1, 0, 1, 0, 1, t3,    2);
    vecs[14] = mk(0, 32'h0,        1, 0, 1, 0, 0, t3,    3);
    vecs[15] = mk(1, 32'h77777777, 1, 0, 1, 0, 0, t3,    3);
    vecs[16] = mk(1, 32'h88888888, 1, 0, 1, 1, 0, t3,    3);
    vecs[17] = mk(1, 32'h99999999, 1, 1, 0, 1, 0, t3,    3);
    vecs[18] = mk(1, 32'hC0000001, 1, 0, 1, 0, 0, t3,    3);
    vecs[19] = mk(1, 32'hC0000002, 1, 0, 1, 1, 0, t3,    3);
    vecs[20] = mk(1, 32'hC0000003, 1, 0, 1, 1, 0, t3,    3);
    vecs[21] = mk(0, 32'h0,        1, 0, 1, 0, 1, t4,    3);
    vecs[22] = mk(0, 32'h0,        1, 0, 1, 0, 0, t4,    4);

    // Reset state
    data_tx_valid_i = 1'b1;
    #2;
    chk("rst_ready",    96'(data_tx_ready_o),    96'd0);
    chk("rst_tvalid",   96'(ptp_ts_axis_tvalid), 96'd0);
    chk("rst_tdata",    ptp_ts_axis_tdata,       96'd0);
    chk("rst_count",    96'(ts_count_o),         96'd0);
    chk("rst_busy",     96'(busy_o),             96'd0);
    chk("datasize",     96'(data_tx_datasize_o), 96'd2);
    data_tx_valid_i = 1'b0;
    @(negedge clk_ptp);
    @(negedge clk_ptp);
    rst_ptp = 1'b0;
    #1;
    chk("post_rst_ready", 96'(data_tx_ready_o), 96'd1);

    // Pack, backpressure and clear vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_ptp);
      data_tx_valid_i    = vecs[i].v;
      data_tx_i          = vecs[i].d;
      ptp_ts_axis_tready = vecs[i].tr;
      clr_i              = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_ready", i), 96'(data_tx_ready_o),    96'(vecs[i].e_rdy));
      chk($sformatf("v%0d_busy", i),  96'(busy_o),             96'(vecs[i].e_busy));
      chk($sformatf("v%0d_tvalid", i),96'(ptp_ts_axis_tvalid), 96'(vecs[i].e_tv));
      chk($sformatf("v%0d_tdata", i), ptp_ts_axis_tdata,       vecs[i].e_td);
      chk($sformatf("v%0d_count", i), 96'(ts_count_o),         96'(vecs[i].e_cnt));
    end
    clr_i = 1'b0;

    // Streaming: 30 back-to-back words, one timestamp every 3 clocks
    ptp_ts_axis_tready = 1'b1;
    for (int i = 0; i < 33; i++) w[i] = 32'h5000_0000 + 32'(i * 7);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk_ptp);
      data_tx_valid_i = (i < 30);
      data_tx_i       = w[i];
      #1;
      if (i < 30) chk($sformatf("s%0d_ready", i), 96'(data_tx_ready_o), 96'd1);
      exp_tv = (i >= 3) && (i % 3 == 0) && (i <= 30);
      chk($sformatf("s%0d_tvalid", i), 96'(ptp_ts_axis_tvalid), 96'(exp_tv));
      if (exp_tv) begin
        exp_td = {w[i-3], w[i-2], w[i-1]};
        chk($sformatf("s%0d_tdata", i), ptp_ts_axis_tdata, exp_td);
      end
    end
    data_tx_valid_i = 1'b0;
    @(negedge clk_ptp);
    #1;
    chk("stream_count", 96'(ts_count_o), 96'd14);

    // Reset while in WORD3 with a timestamp pending
    ptp_ts_axis_tready = 1'b0;
    send_words(5, 32'hD000_0000);
    data_tx_valid_i = 1'b1;
    #1;
    chk("pre_rst_tvalid", 96'(ptp_ts_axis_tvalid), 96'd1);
    chk("pre_rst_busy",   96'(busy_o),             96'd1);
    rst_ptp = 1'b1;
    #1;
    chk("midrst_tvalid", 96'(ptp_ts_axis_tvalid), 96'd0);
    chk("midrst_count",  96'(ts_count_o),         96'd0);
    chk("midrst_busy",   96'(busy_o),             96'd0);
    chk("midrst_ready",  96'(data_tx_ready_o),    96'd0);
    @(negedge clk_ptp);
    #1;
    chk("midrst_ready2", 96'(data_tx_ready_o), 96'd0);
    rst_ptp = 1'b0;
    data_tx_valid_i = 1'b0;
    ptp_ts_axis_tready = 1'b1;
    #1;
    chk("after_rst_ready", 96'(data_tx_ready_o), 96'd1);
    @(negedge clk_ptp);
    @(negedge clk_ptp);
    #1;
    chk("after_rst_tvalid", 96'(ptp_ts_axis_tvalid), 96'd0);
    chk("after_rst_count",  96'(ts_count_o),         96'd0);

    // Counter wrap: 16 timestamps return to 0, 17th gives 1
    send_words(48, 32'hE000_0000);
    @(negedge clk_ptp);
    #1;
    chk("wrap16_count", 96'(ts_count_o), 96'd0);
    send_words(3, 32'hF000_0000);
    @(negedge clk_ptp);
    #1;
    chk("wrap17_tdata", ptp_ts_axis_tdata, 96'hF0000000_F0000001_F0000002);
    chk("wrap17_count", 96'(ts_count_o), 96'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udma_ptp_ts_tx.md
UDMA_PTP_TS_TX -- requirements
Module: udma_ptp_ts_tx

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the emitted-timestamp counter.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
- clk_ptp   in   1    sole clock; all logic posedge
- rst_ptp   in   1    asynchronous, active-high reset
REQ-003 SHALL have the following ports:
- clr_i               in   1          sync abort of partial assembly
- data_tx_datasize_o  out  2          constant 2'b10 (32-bit words)
- data_tx_i           in   32         word from uDMA TX channel (already in clk_ptp domain)
- data_tx_valid_i     in   1          word valid
- data_tx_ready_o     out  1          word accepted when valid&ready
- ptp_ts_axis_tdata   out  96         assembled timestamp
- ptp_ts_axis_tvalid  out  1          AXIS valid
- ptp_ts_axis_tready  in   1          AXIS ready
- ts_count_o          out  CNT_WIDTH  timestamps delivered, wraps
- busy_o              out  1          partial timestamp held (state != IDLE)

Function
REQ-004 SHALL pack three consecutive accepted 32-bit words into one 96-bit timestamp: 1st -> [95:64], 2nd -> [63:32], 3rd -> [31:0].
REQ-005 SHALL use FSM states IDLE (expect 1st), WORD2, WORD3; each accepted word advances IDLE->WORD2->WORD3->IDLE; no accept = hold state.
REQ-006 SHALL accept words into an internal 64-bit hold register in IDLE and WORD2 unconditionally (data_tx_ready_o=1).
REQ-007 SHALL, in WORD3, drive data_tx_ready_o = ~ptp_ts_axis_tvalid | ptp_ts_axis_tready (output slot free or draining this cycle).
REQ-008 SHALL, on WORD3 accept, load ptp_ts_axis_tdata = {hold[63:0], data_tx_i} and set ptp_ts_axis_tvalid next cycle (latency 1 clock from 3rd word handshake).
REQ-009 SHALL keep ptp_ts_axis_tdata stable and tvalid high until tvalid&tready; tvalid never withdrawn without handshake.
REQ-010 SHALL clear tvalid on handshake unless a new timestamp loads the same cycle, in which case tvalid stays 1 with new data (sustained throughput: one timestamp per 3 clocks).
REQ-011 SHALL increment ts_count_o by 1 on each tvalid&tready, wrapping 2^CNT_WIDTH-1 -> 0.
REQ-012 SHALL, when clr_i=1, force data_tx_ready_o=0, return FSM to IDLE, discard hold register; clr_i wins over a simultaneous word.
REQ-013 SHALL leave the output register, tvalid and ts_count_o unaffected by clr_i.
REQ-014 SHALL drive busy_o = (state != IDLE) combinationally from the state register.
REQ-015 SHALL drive data_tx_datasize_o = 2'b10 constantly.

Reset
REQ-016 SHALL, while rst_ptp=1, hold state=IDLE, hold register=0, ptp_ts_axis_tdata=0, ptp_ts_axis_tvalid=0, ts_count_o=0, busy_o=0, data_tx_ready_o=0.
REQ-017 SHALL, on reset asserted mid-assembly or with tvalid pending, discard partial words and pending timestamp without emitting them.
REQ-018 SHALL, first cycle after reset release, present data_tx_ready_o=1 in IDLE.

Structure
REQ-019 SHALL take the FSM state enum and constants TS_WIDTH=96 and WORD_WIDTH=32 from shared package udma_ptp_ts_pkg, also used by the RX bridge.
REQ-020 SHALL be a single module with no sub-module; FSM, hold register, output register and counter inline, roughly 150-250 lines of RTL.

Verification
REQ-021 SHALL check basic pack: words 0xAAAA0001, 0x00000002, 0x00000003 with tready=1 -> one beat tdata=0xAAAA0001_00000002_00000003, tvalid 1 clock after 3rd accept, ts_count_o=1.
REQ-022 SHALL check backpressure: tready=0 with timestamp pending, 6 further words offered -> first 2 accepted, 3rd stalled (ready_o=0), tdata stable; tready=1 -> both timestamps delivered in order, count=2.
REQ-023 SHALL check streaming: 30 back-to-back words, tready=1 -> 10 timestamps, one every 3 clocks, no ready_o drop, count=10.
REQ-024 SHALL check clear: 2 words accepted, then clr_i with a valid word -> word dropped, busy_o=0; next 3 words form a clean timestamp.
REQ-025 SHALL check mid-op reset: rst_ptp pulse in WORD3 with tvalid=1 -> tvalid=0, count=0, state IDLE, ready_o=0 during reset.
REQ-026 SHALL check wrap: CNT_WIDTH=4, 17 timestamps -> ts_count_o=1.
